data_memory_ws: RTL and testbench

//  Parametrised MEM-stage data memory for the ARM32 pipeline: DEPTH x 32-bit words at BASE_ADDR.

---
 rtl/data_memory_ws.sv | 163 ++++++++++++++++
 tb/tb_data_memory_ws.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ws.sv
// MEM-stage data memory with configurable wait states, a ready handshake and byte/half/word access.
// Out-of-range or misaligned accesses complete normally but are flagged and have no effect.
module data_memory_ws #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [1:0]  MEM_SIZE,
    input  logic [31:0] alu_res,
    input  logic [31:0] rm_val,
    output logic [31:0] data_mem,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        addr_err
);
    localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        wr_q;
    logic [31:0] mem_q [DEPTH];

    logic            req;
    logic            commit;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic [1:0]      acc_size;
    logic            acc_wr;
    logic [31:0]     word_off;
    logic            in_range;
    logic            misaligned;
    logic            err;
    logic [IdxW-1:0] idx;
    logic [31:0]     rd_word;
    logic [31:0]     rd_data;
    logic [31:0]     wr_word;

    assign req = MEM_R_EN | MEM_W_EN;

    // A zero-wait access commits on the same edge that samples it, so it must use the live inputs.
    always_comb begin
        if (state_q == StIdle) begin
            acc_addr  = alu_res;
            acc_wdata = rm_val;
            acc_size  = MEM_SIZE;
            acc_wr    = MEM_W_EN;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_size  = size_q;
            acc_wr    = wr_q;
        end
    end

    assign commit = ((state_q == StIdle) && req && (WAIT_CYCLES == 0)) ||
                    ((state_q == StWait) && (cnt_q == 4'd0));

    assign word_off = (acc_addr - BASE_ADDR) >> 2;
    assign in_range = (acc_addr >= BASE_ADDR) && (word_off < DEPTH);
    assign idx      = word_off[IdxW-1:0];

    always_comb begin
        case (acc_size)
            2'b10:   misaligned = 1'b0;
            2'b01:   misaligned = acc_addr[0];
            default: misaligned = (acc_addr[1:0] != 2'b00);
        endcase
    end

    assign err     = !in_range || misaligned;
    assign rd_word = mem_q[idx];

    always_comb begin
        case (acc_size)
            2'b10:   rd_data = {24'h0, rd_word[{acc_addr[1:0], 3'b000} +: 8]};
            2'b01:   rd_data = {16'h0, rd_word[{acc_addr[1], 4'b0000} +: 16]};
            default: rd_data = rd_word;
        endcase
    end

    // Merge the store into the current word so untouched lanes are preserved.
    always_comb begin
        wr_word = rd_word;
        case (acc_size)
            2'b10:   wr_word[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
            2'b01:   wr_word[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
            default: wr_word = acc_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && acc_wr && !err) begin
            mem_q[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            wr_q      <= 1'b0;
            data_mem  <= '0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            addr_err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q   <= alu_res;
                        wdata_q  <= rm_val;
                        size_q   <= MEM_SIZE;
                        wr_q     <= MEM_W_EN;
                        cnt_q    <= CntInit;
                        state_q  <= (WAIT_CYCLES == 0) ? StDone : StWait;
                        mem_busy <= 1'b1;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    state_q  <= StIdle;
                    mem_busy <= 1'b0;
                end
                default: begin
                    state_q  <= StIdle;
                    mem_busy <= 1'b0;
                end
            endcase
            if (commit) begin
                mem_ready <= 1'b1;
                addr_err  <= err;
                if (!acc_wr) begin
                    data_mem <= err ? 32'h0 : rd_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory_ws.sv
// Bench for data_memory_ws: two instances (2 and 0 wait states) checked every cycle against a
// byte-addressed reference model, plus directed scenarios with literal expectations.
module tb_data_memory_ws;
    localparam int DEPTH = 64;
    localparam int BASE  = 1024;
    localparam int W0    = 2;
    localparam int W1    = 0;

    logic        clk;
    logic        rst;
    logic [1:0]  r_en;
    logic [1:0]  w_en;
    logic [1:0]  sz   [2];
    logic [31:0] ad   [2];
    logic [31:0] wv   [2];
    logic [31:0] dout [2];
    logic [1:0]  rdy;
    logic [1:0]  bsy;
    logic [1:0]  aerr;

    logic [31:0] exp_data  [2];
    logic [1:0]  exp_ready;
    logic [1:0]  exp_busy;
    logic [1:0]  exp_err;
    logic [7:0]  mbytes [2][4*DEPTH];

    int checks = 0;
    int errors = 0;

    data_memory_ws #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W0)) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]), .MEM_SIZE(sz[0]),
        .alu_res(ad[0]), .rm_val(wv[0]), .data_mem(dout[0]), .mem_ready(rdy[0]),
        .mem_busy(bsy[0]), .addr_err(aerr[0])
    );

    data_memory_ws #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W1)) dut_w0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]), .MEM_SIZE(sz[1]),
        .alu_res(ad[1]), .rm_val(wv[1]), .data_mem(dout[1]), .mem_ready(rdy[1]),
        .mem_busy(bsy[1]), .addr_err(aerr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(exp_ready[i]));
            check($sformatf("busy%0d", i), 32'(bsy[i]), 32'(exp_busy[i]));
            check($sformatf("addr_err%0d", i), 32'(aerr[i]), 32'(exp_err[i]));
            check($sformatf("data_mem%0d", i), dout[i], exp_data[i]);
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4*DEPTH; j++) mbytes[i][j] = 8'h0;
        end
    endtask

    // Little-endian byte-array view of the memory.
    task automatic model_access(input int inst, input bit rd, input bit wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output bit e, output logic [31:0] rdat);
        int     n;
        longint a;
        longint off;
        n    = (size == 2'd2) ? 1 : (size == 2'd1) ? 2 : 4;
        a    = longint'(addr);
        e    = (a < BASE) || (a >= BASE + 4*DEPTH) || ((a % n) != 0);
        rdat = 32'h0;
        off  = a - BASE;
        if (!e) begin
            if (wr) begin
                for (int j = 0; j < n; j++) mbytes[inst][off+j] = wd[8*j +: 8];
            end else if (rd) begin
                for (int j = 0; j < n; j++) rdat = rdat | (32'(mbytes[inst][off+j]) << (8*j));
            end
        end
    endtask

    task automatic set_idle_exp();
        exp_ready = 2'b00;
        exp_busy  = 2'b00;
        exp_err   = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            set_idle_exp();
        end
    endtask

    task automatic do_access(input int inst, input bit rd, input bit wr, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output bit e, output logic [31:0] rdat);
        int lat;
        lat = (inst == 0) ? W0 + 1 : W1 + 1;
        @(posedge clk); #1;
        set_idle_exp();
        r_en[inst] = rd;
        w_en[inst] = wr;
        sz[inst]   = size;
        ad[inst]   = addr;
        wv[inst]   = wd;
        model_access(inst, rd, wr, size, addr, wd, e, rdat);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            exp_busy[inst]  = 1'b1;
            exp_ready[inst] = (k == lat);
            exp_err[inst]   = (k == lat) && e;
            if (k == lat && rd && !wr) exp_data[inst] = rdat;
            // Inputs are junk once sampled; the access must not notice.
            r_en[inst] = (k == lat) ? 1'b0 : 1'($urandom);
            w_en[inst] = (k == lat) ? 1'b0 : 1'($urandom);
            sz[inst]   = 2'($urandom);
            ad[inst]   = $urandom;
            wv[inst]   = $urandom;
        end
    endtask

    initial begin
        bit          e;
        logic [31:0] rdat;
        int          inst;
        int          op;
        int          n;
        logic [1:0]  size;
        logic [31:0] addr;

        rst  = 1'b1;
        r_en = 2'b00;
        w_en = 2'b00;
        for (int i = 0; i < 2; i++) begin
            sz[i] = 2'b00; ad[i] = 32'h0; wv[i] = 32'h0; exp_data[i] = 32'h0;
        end
        set_idle_exp();
        model_clear();
        #11;
        check("reset_data", dout[0], 32'h0);
        check("reset_ready", 32'(rdy[0]), 32'h0);
        #1 rst = 1'b0;
        idle(2);

        // Word write, then word read with hold across idle cycles.
        do_access(0, 1'b0, 1'b1, 2'b00, 32'd1024, 32'hDEADBEEF, e, rdat);
        check("wr_word_err", 32'(e), 32'h0);
        do_access(0, 1'b1, 1'b0, 2'b00, 32'd1024, 32'h0, e, rdat);
        check("rd_word_model", rdat, 32'hDEADBEEF);
        idle(3);
        check("rd_word_hold", dout[0], 32'hDEADBEEF);

        // Byte write merges into the word; half read selects upper lanes.
        do_access(0, 1'b0, 1'b1, 2'b10, 32'd1026, 32'h00000055, e, rdat);
        do_access(0, 1'b1, 1'b0, 2'b00, 32'd1024, 32'h0, e, rdat);
        check("rd_merged_model", rdat, 32'hDE55BEEF);
        do_access(0, 1'b1, 1'b0, 2'b01, 32'd1026, 32'h0, e, rdat);
        check("rd_half_model", rdat, 32'h0000DE55);
        idle(1);
        check("rd_half_dut", dout[0], 32'h0000DE55);

        // Rejected accesses.
        do_access(0, 1'b0, 1'b1, 2'b00, 32'd1020, 32'h11111111, e, rdat);
        check("err_below", 32'(e), 32'h1);
        do_access(0, 1'b0, 1'b1, 2'b00, 32'(BASE + 4*DEPTH), 32'h22222222, e, rdat);
        check("err_above", 32'(e), 32'h1);
        do_access(0, 1'b1, 1'b0, 2'b00, 32'd1025, 32'h0, e, rdat);
        check("err_misalign", 32'(e), 32'h1);
        check("err_rdat", rdat, 32'h0);
        do_access(0, 1'b1, 1'b0, 2'b00, 32'd1024, 32'h0, e, rdat);
        check("after_err_model", rdat, 32'hDE55BEEF);

        // Reset in the middle of a write's wait states.
        @(posedge clk); #1;
        set_idle_exp();
        r_en[0] = 1'b0; w_en[0] = 1'b1; sz[0] = 2'b00; ad[0] = 32'd1028; wv[0] = 32'h12345678;
        @(posedge clk); #1;
        exp_busy[0] = 1'b1;
        #2;
        rst = 1'b1;
        r_en = 2'b00;
        w_en = 2'b00;
        model_clear();
        set_idle_exp();
        exp_data[0] = 32'h0;
        exp_data[1] = 32'h0;
        #1;
        check("rst_busy", 32'(bsy[0]), 32'h0);
        check("rst_ready", 32'(rdy[0]), 32'h0);
        check("rst_err", 32'(aerr[0]), 32'h0);
        check("rst_data", dout[0], 32'h0);
        @(posedge clk); #3;
        rst = 1'b0;
        do_access(0, 1'b1, 1'b0, 2'b00, 32'd1028, 32'h0, e, rdat);
        check("rst_rd1028", rdat, 32'h0);
        do_access(0, 1'b1, 1'b0, 2'b00, 32'd1024, 32'h0, e, rdat);
        check("rst_rd1024", rdat, 32'h0);

        // Zero wait states: both enables act as a write and leave read data alone.
        do_access(1, 1'b0, 1'b1, 2'b00, 32'd1036, 32'h11223344, e, rdat);
        do_access(1, 1'b1, 1'b0, 2'b00, 32'd1036, 32'h0, e, rdat);
        do_access(1, 1'b1, 1'b1, 2'b00, 32'd1032, 32'hCAFEF00D, e, rdat);
        idle(1);
        check("both_hold", dout[1], 32'h11223344);
        do_access(1, 1'b1, 1'b0, 2'b00, 32'd1032, 32'h0, e, rdat);
        check("both_wrote", rdat, 32'hCAFEF00D);

        for (int t = 0; t < 300; t++) begin
            inst = int'($urandom_range(0, 1));
            op   = int'($urandom_range(0, 3));
            size = 2'($urandom_range(0, 3));
            n    = (size == 2'd2) ? 1 : (size == 2'd1) ? 2 : 4;
            addr = 32'(BASE - 8) + $urandom_range(0, 4*DEPTH + 15);
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
            do_access(inst, op != 2, op >= 2, size, addr, $urandom, e, rdat);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
